// File: rtl/dlx_global_pkg.sv
// Shared DLX types: instruction-cache geometry, tag/index/line typedefs and refill FSM states.
// Types only; no logic, no latency, no backpressure.
package dlx_global_pkg;
  localparam int IC_LINES = 32;

  typedef logic [6:0]   ic_tag;
  typedef logic [4:0]   ic_index;
  typedef logic [127:0] cacheline;

  typedef enum logic {IC_IDLE, IC_REFILL} ic_state;
endpackage

// File: rtl/dlx_icache_array.sv
// Tag/data/valid storage for the direct-mapped I-cache: combinational read, one write port,
// write visible at the next edge; global invalidate beats a same-edge valid set. No backpressure.
module dlx_icache_array
  import dlx_global_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  ic_index  rd_idx,
  output ic_tag    rd_tag,
  output logic     rd_valid,
  output cacheline rd_line,
  input  logic     wr_en,
  input  ic_index  wr_idx,
  input  ic_tag    wr_tag,
  input  cacheline wr_line,
  input  logic     wr_set_valid,
  input  logic     inval_all
);
  ic_tag               tag_mem  [IC_LINES];
  cacheline            data_mem [IC_LINES];
  logic [IC_LINES-1:0] valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (wr_en) valid_q[wr_idx] <= wr_set_valid;
      if (inval_all) valid_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_line;
    end
  end

  assign rd_tag   = tag_mem[rd_idx];
  assign rd_valid = valid_q[rd_idx];
  assign rd_line  = data_mem[rd_idx];
endmodule

// File: rtl/dlx_icache.sv
// Direct-mapped read-only I-cache: hits return in the same cycle, a miss costs >= 2 cycles.
// Stalls IF for the whole refill; refill holds mem_req/mem_addr until mem_ack.
module dlx_icache
  import dlx_global_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int TAG_W  = 7,
  parameter int IDX_W  = 5,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              flush,
  output logic [31:0]       ic_instr,
  output logic              ic_valid,
  output logic              ic_stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_line,
  output logic [15:0]       miss_cnt
);
  ic_state  state;
  ic_tag    miss_tag;
  ic_index  miss_idx;
  logic     discard;

  ic_tag    rd_tag;
  logic     rd_valid;
  cacheline rd_line;

  ic_tag    f_tag;
  ic_index  f_idx;
  logic [1:0] f_word;
  logic     hit, idle, miss, wr_en;
  wire      unused_byte_bits = ^if_addr[1:0];

  assign f_tag  = if_addr[ADDR_W-1 -: TAG_W];
  assign f_idx  = if_addr[4 +: IDX_W];
  assign f_word = if_addr[3:2];

  assign hit  = rd_valid && (rd_tag == f_tag);
  assign idle = (state == IC_IDLE) && !rst;
  // A flush in the same cycle as a fetch forces a refill, even on a tag match.
  assign miss = idle && if_req && (!hit || flush);
  assign wr_en = (state == IC_REFILL) && mem_ack && !rst;

  always_comb begin
    ic_valid = idle && if_req && hit && !flush;
    ic_stall = !rst && ((state == IC_REFILL) || miss);
    ic_instr = ic_valid ? rd_line[{f_word, 5'b00000} +: 32] : 32'h0;
  end

  dlx_icache_array u_array (
    .clk          (clk),
    .rst          (rst),
    .rd_idx       (f_idx),
    .rd_tag       (rd_tag),
    .rd_valid     (rd_valid),
    .rd_line      (rd_line),
    .wr_en        (wr_en),
    .wr_idx       (miss_idx),
    .wr_tag       (miss_tag),
    .wr_line      (mem_line),
    .wr_set_valid (!discard && !flush),
    .inval_all    (flush && !rst)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IC_IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      miss_cnt <= '0;
      discard  <= 1'b0;
      miss_tag <= '0;
      miss_idx <= '0;
    end else begin
      case (state)
        IC_IDLE: begin
          if (miss) begin
            state    <= IC_REFILL;
            mem_req  <= 1'b1;
            mem_addr <= {f_tag, f_idx, 4'b0000};
            miss_tag <= f_tag;
            miss_idx <= f_idx;
            if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
          end
        end
        IC_REFILL: begin
          if (flush) discard <= 1'b1;
          if (mem_ack) begin
            state   <= IC_IDLE;
            mem_req <= 1'b0;
            discard <= 1'b0;
          end
        end
        default: state <= IC_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dlx_icache.sv
// Directed vector bench for dlx_icache with a line-content model and a counter saturation sequence.
// Inputs change 1 ns after the rising edge; outputs are sampled mid-cycle.
module tb_dlx_icache;
  logic         clk;
  logic         rst;
  logic         if_req;
  logic [15:0]  if_addr;
  logic         flush;
  logic [31:0]  ic_instr;
  logic         ic_valid;
  logic         ic_stall;
  logic         mem_req;
  logic [15:0]  mem_addr;
  logic         mem_ack;
  logic [127:0] mem_line;
  logic [15:0]  miss_cnt;

  int n_vec;
  int n_bad;

  typedef struct {
    logic        rst;
    logic        req;
    logic [15:0] addr;
    logic        flush;
    logic        ack;
    logic        vld;
    logic        stall;
    logic [31:0] instr;
    logic        mreq;
    logic [15:0] maddr;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  dlx_icache dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .flush    (flush),
    .ic_instr (ic_instr),
    .ic_valid (ic_valid),
    .ic_stall (ic_stall),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_line (mem_line),
    .miss_cnt (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word w of the line at address a: 0x2000_0000 + (a[15:4] << 12) + 4*w + 1.
  function automatic logic [127:0] mk_line(input logic [15:0] a);
    logic [127:0] l;
    logic [31:0]  base;
    base = 32'h2000_0000 + (32'(a[15:4]) << 12);
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = base + 32'(w * 4 + 1);
    return l;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic q, input logic [15:0] a,
                       input logic f, input logic k);
    @(posedge clk);
    #1;
    rst      = r;
    if_req   = q;
    if_addr  = a;
    flush    = f;
    mem_ack  = k;
    mem_line = mk_line(a);
    #4;
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v.rst, v.req, v.addr, v.flush, v.ack);
    n_vec++;
    check($sformatf("v%0d ic_valid", idx), 32'(ic_valid), 32'(v.vld));
    check($sformatf("v%0d ic_stall", idx), 32'(ic_stall), 32'(v.stall));
    check($sformatf("v%0d ic_instr", idx), ic_instr, v.instr);
    check($sformatf("v%0d mem_req", idx), 32'(mem_req), 32'(v.mreq));
    check($sformatf("v%0d mem_addr", idx), 32'(mem_addr), 32'(v.maddr));
    check($sformatf("v%0d miss_cnt", idx), 32'(miss_cnt), 32'(v.cnt));
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] exp_cnt;
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; flush = 1'b0; mem_ack = 1'b0; mem_line = '0;

    //                rst req addr    fl ack  vld st instr         mreq maddr    cnt
    tbl.push_back('{1'b1,1'b1,16'h0104,1'b0,1'b0, 1'b0,1'b0,32'h0,        1'b0,16'h0000,16'd0});
    tbl.push_back('{1'b0,1'b1,16'h0104,1'b0,1'b0, 1'b0,1'b1,32'h0,        1'b0,16'h0000,16'd0});
    tbl.push_back('{1'b0,1'b1,16'h0104,1'b0,1'b0, 1'b0,1'b1,32'h0,        1'b1,16'h0100,16'd1});
    tbl.push_back('{1'b0,1'b1,16'h0104,1'b0,1'b0, 1'b0,1'b1,32'h0,        1'b1,16'h0100,16'd1});
    tbl.push_back('{1'b0,1'b1,16'h0104,1'b0,1'b0, 1'b0,1'b1,32'h0,        1'b1,16'h0100,16'd1});
    tbl.push_back('{1'b0,1'b1,16'h0104,1'b0,1'b1, 1'b0,1'b1,32'h0,        1'b1,16'h0100,16'd1});
    tbl.push_back('{1'b0,1'b1,16'h0104,1'b0,1'b0, 1'b1,1'b0,32'h2001_0005,1'b0,16'h0100,16'd1});
    tbl.push_back('{1'b0,1'b1,16'h0100,1'b0,1'b0, 1'b1,1'b0,32'h2001_0001,1'b0,16'h0100,16'd1});
    tbl.push_back('{1'b0,1'b1,16'h0108,1'b0,1'b0, 1'b1,1'b0,32'h2001_0009,1'b0,16'h0100,16'd1});
    tbl.push_back('{1'b0,1'b1,16'h010C,1'b0,1'b0, 1'b1,1'b0,32'h2001_000D,1'b0,16'h0100,16'd1});
    // conflict on index 0x10, minimum-penalty refills
    tbl.push_back('{1'b0,1'b1,16'h0300,1'b0,1'b0, 1'b0,1'b1,32'h0,        1'b0,16'h0100,16'd1});
    tbl.push_back('{1'b0,1'b1,16'h0300,1'b0,1'b1, 1'b0,1'b1,32'h0,        1'b1,16'h0300,16'd2});
    tbl.push_back('{1'b0,1'b1,16'h0300,1'b0,1'b0, 1'b1,1'b0,32'h2003_0001,1'b0,16'h0300,16'd2});
    tbl.push_back('{1'b0,1'b1,16'h0100,1'b0,1'b0, 1'b0,1'b1,32'h0,        1'b0,16'h0300,16'd2});
    tbl.push_back('{1'b0,1'b1,16'h0100,1'b0,1'b1, 1'b0,1'b1,32'h0,        1'b1,16'h0100,16'd3});
    tbl.push_back('{1'b0,1'b1,16'h0100,1'b0,1'b0, 1'b1,1'b0,32'h2001_0001,1'b0,16'h0100,16'd3});
    // flush during refill: data written, line stays invalid
    tbl.push_back('{1'b0,1'b1,16'h0200,1'b0,1'b0, 1'b0,1'b1,32'h0,        1'b0,16'h0100,16'd3});
    tbl.push_back('{1'b0,1'b1,16'h0200,1'b1,1'b0, 1'b0,1'b1,32'h0,        1'b1,16'h0200,16'd4});
    tbl.push_back('{1'b0,1'b1,16'h0200,1'b0,1'b1, 1'b0,1'b1,32'h0,        1'b1,16'h0200,16'd4});
    tbl.push_back('{1'b0,1'b1,16'h0200,1'b0,1'b0, 1'b0,1'b1,32'h0,        1'b0,16'h0200,16'd4});
    tbl.push_back('{1'b0,1'b1,16'h0200,1'b0,1'b1, 1'b0,1'b1,32'h0,        1'b1,16'h0200,16'd5});
    tbl.push_back('{1'b0,1'b1,16'h0200,1'b0,1'b0, 1'b1,1'b0,32'h2002_0001,1'b0,16'h0200,16'd5});
    // flush together with ack: flush wins
    tbl.push_back('{1'b0,1'b1,16'h0100,1'b0,1'b0, 1'b0,1'b1,32'h0,        1'b0,16'h0200,16'd5});
    tbl.push_back('{1'b0,1'b1,16'h0100,1'b1,1'b1, 1'b0,1'b1,32'h0,        1'b1,16'h0100,16'd6});
    tbl.push_back('{1'b0,1'b1,16'h0100,1'b0,1'b0, 1'b0,1'b1,32'h0,        1'b0,16'h0100,16'd6});
    tbl.push_back('{1'b0,1'b1,16'h0100,1'b0,1'b1, 1'b0,1'b1,32'h0,        1'b1,16'h0100,16'd7});
    tbl.push_back('{1'b0,1'b1,16'h0100,1'b0,1'b0, 1'b1,1'b0,32'h2001_0001,1'b0,16'h0100,16'd7});
    // flush in IDLE on a hitting fetch turns it into a miss
    tbl.push_back('{1'b0,1'b1,16'h0100,1'b1,1'b0, 1'b0,1'b1,32'h0,        1'b0,16'h0100,16'd7});
    tbl.push_back('{1'b0,1'b1,16'h0100,1'b0,1'b1, 1'b0,1'b1,32'h0,        1'b1,16'h0100,16'd8});
    tbl.push_back('{1'b0,1'b1,16'h0100,1'b0,1'b0, 1'b1,1'b0,32'h2001_0001,1'b0,16'h0100,16'd8});
    tbl.push_back('{1'b0,1'b0,16'h0100,1'b0,1'b0, 1'b0,1'b0,32'h0,        1'b0,16'h0100,16'd8});
    // reset mid-refill, ack in the cycle after reset is ignored
    tbl.push_back('{1'b0,1'b1,16'h0200,1'b0,1'b0, 1'b0,1'b1,32'h0,        1'b0,16'h0100,16'd8});
    tbl.push_back('{1'b1,1'b1,16'h0200,1'b0,1'b0, 1'b0,1'b0,32'h0,        1'b1,16'h0200,16'd9});
    tbl.push_back('{1'b0,1'b1,16'h0200,1'b0,1'b1, 1'b0,1'b1,32'h0,        1'b0,16'h0000,16'd0});
    tbl.push_back('{1'b0,1'b1,16'h0200,1'b0,1'b0, 1'b0,1'b1,32'h0,        1'b1,16'h0200,16'd1});
    tbl.push_back('{1'b0,1'b1,16'h0200,1'b0,1'b1, 1'b0,1'b1,32'h0,        1'b1,16'h0200,16'd1});
    tbl.push_back('{1'b0,1'b1,16'h0200,1'b0,1'b0, 1'b1,1'b0,32'h2002_0001,1'b0,16'h0200,16'd1});

    @(posedge clk);
    @(posedge clk);
    foreach (tbl[i]) apply(tbl[i], i);

    // Saturation: preload the counter just below the limit, then force six misses on index 0.
    force dut.miss_cnt = 16'hFFFA;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    release dut.miss_cnt;
    n_vec++;
    check("sat preload", 32'(miss_cnt), 32'hFFFA);
    exp_cnt = 16'hFFFA;
    for (int i = 0; i < 6; i++) begin
      a = 16'h0400 + 16'(i * 16'h0200);
      drive(1'b0, 1'b1, a, 1'b0, 1'b0);
      n_vec++;
      check($sformatf("sat%0d stall", i), 32'(ic_stall), 32'h1);
      drive(1'b0, 1'b1, a, 1'b0, 1'b1);
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      n_vec++;
      check($sformatf("sat%0d mem_req", i), 32'(mem_req), 32'h1);
      check($sformatf("sat%0d mem_addr", i), 32'(mem_addr), 32'(a));
      check($sformatf("sat%0d miss_cnt", i), 32'(miss_cnt), 32'(exp_cnt));
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    n_vec++;
    check("sat final", 32'(miss_cnt), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
